// File: rtl/pcm_frame_fifo.sv
// pcm_frame_fifo: pairs left/right PCM words into stereo frames and buffers them
// in a first-word-fall-through FIFO. The input is never back-pressured; frames that find the FIFO full are dropped and counted.
module pcm_frame_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       overflow_cnt,
  output logic              sync_err
);

  localparam logic            CHAN_L  = 1'b0;
  localparam logic            CHAN_R  = 1'b1;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  typedef enum logic {WAIT_L, WAIT_R} pair_state_t;

  pair_state_t       state;
  logic [DATA_W-1:0] left_hold;

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] mem_left  [DEPTH];
  logic [DATA_W-1:0] mem_right [DEPTH];

  logic accept;
  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic empty;
  logic full;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign accept   = in_valid & in_ready;
  assign push_req = accept & (state == WAIT_R) & (in_chan == CHAN_R) & ~clear;
  assign pop      = ~empty & out_ready & ~clear;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the frame.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_L;
      left_hold <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (clear) begin
        state <= WAIT_L;
      end else if (accept) begin
        case (state)
          WAIT_L: begin
            if (in_chan == CHAN_L) begin
              left_hold <= in_data;
              state     <= WAIT_R;
            end else begin
              sync_err <= 1'b1;
            end
          end
          WAIT_R: begin
            if (in_chan == CHAN_R) begin
              state <= WAIT_L;
            end else begin
              left_hold <= in_data;
              sync_err  <= 1'b1;
            end
          end
          default: state <= WAIT_L;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (clear) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != CNT_MAX)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // Storage is deliberately not reset; the empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_left[wr_addr]  <= left_hold;
      mem_right[wr_addr] <= in_data;
    end
  end

  assign out_valid = ~empty;
  assign out_left  = empty ? '0 : mem_left[rd_addr];
  assign out_right = empty ? '0 : mem_right[rd_addr];
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: doc/pcm_frame_fifo.md
# pcm_frame_fifo

Downstream stage of the ADC interface: consumes the 24-bit PCM words it produces, pairs left/right words into stereo frames, and buffers frames in a first-word-fall-through FIFO for the DSP core. The ADC runs in master mode and cannot be stalled, so the block never back-pressures the input; frames arriving while the FIFO is full are dropped and counted. Channel-order errors are detected and resynchronised on the next left word.

## Interface
- DATA_W, 24: PCM sample width.
- DEPTH, 16: FIFO depth in stereo frames; power of two, ≥ 2.
- ADDR_W, 4: log2(DEPTH).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush: empties FIFO, returns pairing FSM to WAIT_L, zeroes overflow_cnt.
- in_valid  in  1  input word present this cycle.
- in_ready  out  1  input accepted; 1 whenever not in reset.
- in_data  in  DATA_W  PCM sample, two's complement.
- in_chan  in  1  0 = left, 1 = right.
- out_valid  out  1  FIFO non-empty; head frame on out_left/out_right.
- out_ready  in  1  consumer takes head frame when out_valid & out_ready.
- out_left  out  DATA_W  head frame left sample.
- out_right  out  DATA_W  head frame right sample.
- level  out  ADDR_W+1  frames currently stored, 0..DEPTH.
- overflow_cnt  out  16  frames dropped because FIFO full; saturates at 16'hFFFF.
- sync_err  out  1  one-cycle pulse on a channel-order error.

## Operation
- Input accept: word accepted on every cycle with in_valid & in_ready.
- Pairing FSM, two states:
  - WAIT_L: left word -> latch into left_hold, go WAIT_R. Right word -> discard, pulse sync_err, stay.
  - WAIT_R: right word -> form frame {left_hold, in_data}, request push, go WAIT_L. Left word -> overwrite left_hold, pulse sync_err, stay WAIT_R.
- Push: if FIFO not full, or a pop occurs in the same cycle, frame written at wr_ptr, wr_ptr advances. Otherwise frame dropped, overflow_cnt += 1 (saturating); FSM still returns to WAIT_L.
- Pop: out_valid & out_ready advances rd_ptr.
- Pointers ADDR_W+1 bits with wrap bit; empty = pointers equal; full = addresses equal and wrap bits differ. level = wr_ptr - rd_ptr.
- Simultaneous push and pop: both take effect; level unchanged; legal when full (slot freed by pop is reused) and when non-empty. When empty, only push takes effect (out_valid was 0).
- clear has priority over concurrent push/pop: the frame completing in the clear cycle is discarded, not counted as overflow; sync_err not asserted during clear.
- Samples pass through unmodified; no arithmetic on data.

## Timing
- Reset values: in_ready 0 while rst asserted, 1 from first clock edge after release; out_valid 0; out_left/out_right 0 (storage array not reset, outputs gated to 0 while empty); level 0; overflow_cnt 0; sync_err 0; FSM WAIT_L.
- Latency: right word accepted at edge N -> frame in FIFO, out_valid = 1 and data valid after edge N (visible during cycle N+1) when FIFO was empty.
- FWFT: out_left/out_right are combinational from storage at rd_ptr; stable while out_valid & !out_ready.
- level, out_valid, full updated on the same edge as the push/pop.
- sync_err: registered, high for exactly the cycle after the offending word's acceptance edge.
- Reset mid-frame: partial left_hold discarded; FSM back to WAIT_L; FIFO contents lost.
- Throughput: one input word per cycle, one frame out per cycle sustained.

## Test plan
- Basic pairing: L=24'h000001, R=24'h000002, out_ready=0 -> one cycle later out_valid=1, out_left=1, out_right=2, level=1; assert out_ready one cycle -> out_valid=0, level=0.
- Order errors: R=24'hAAAAAA first -> sync_err pulse, level stays 0; then L=5, L=6, R=7 -> second sync_err pulse, single frame {6,7}.
- Overflow: out_ready=0, push DEPTH+3 frames -> level=16, overflow_cnt=3, head still first frame; then drain -> 16 frames in order, no lost/duplicated frames.
- Full with simultaneous push/pop: FIFO full, out_ready=1 on cycle a right word completes -> frame accepted, level stays 16, overflow_cnt unchanged.
- clear: 5 frames stored and FSM in WAIT_R, assert clear with completing right word -> next cycle level=0, out_valid=0, overflow_cnt=0, FSM WAIT_L (next R produces sync_err).
- Async reset mid-frame: assert rst between L and R -> all outputs at reset values immediately; after release, R alone gives sync_err, L/R pair produces exactly one frame.
